// File: rtl/button_event_ctrl.sv
// Gesture classifier for one debounced button channel.
//
// Consumes one-cycle press/release edge pulses. Classifies each gesture as a
// single click, a double click or a long press. While a long press is held,
// it emits auto-repeat pulses. A prescaler derives a 1 ms tick from clk. A
// millisecond counter times each state. Both counters clear on every state
// change and on every repeat pulse, so each timeout lands exactly
// T*TICK_DIV clocks after its starting edge.
//
// Ports:
//   clk           system clock
//   reset_p       asynchronous active-high reset
//   btn_pe        debounced press edge, one-cycle pulse
//   btn_ne        debounced release edge, one-cycle pulse
//   single_click  one-cycle pulse, single click recognised
//   double_click  one-cycle pulse, double click recognised
//   long_press    one-cycle pulse, long-press threshold reached
//   repeat_pulse  one-cycle pulse, every REPEAT_MS while a long press is held
//   held          level, 1 while the button is considered pressed
//   state_dbg     current FSM state encoding (IDLE=0 .. LONG=4)
module button_event_ctrl #(
    parameter int unsigned TICK_DIV  = 100000,
    parameter int unsigned LONG_MS   = 1000,
    parameter int unsigned DBL_MS    = 300,
    parameter int unsigned REPEAT_MS = 200
) (
    input  logic       clk,
    input  logic       reset_p,
    input  logic       btn_pe,
    input  logic       btn_ne,
    output logic       single_click,
    output logic       double_click,
    output logic       long_press,
    output logic       repeat_pulse,
    output logic       held,
    output logic [2:0] state_dbg
);

    localparam int unsigned MaxLd = (LONG_MS > DBL_MS) ? LONG_MS : DBL_MS;
    localparam int unsigned MaxMs = (MaxLd > REPEAT_MS) ? MaxLd : REPEAT_MS;
    localparam int unsigned MsW   = $clog2(MaxMs + 1);
    localparam int unsigned PsW   = $clog2(TICK_DIV);

    localparam logic [PsW-1:0] PsLast  = PsW'(TICK_DIV - 1);
    localparam logic [MsW-1:0] LongEnd = MsW'(LONG_MS - 1);
    localparam logic [MsW-1:0] DblEnd  = MsW'(DBL_MS - 1);
    localparam logic [MsW-1:0] RepEnd  = MsW'(REPEAT_MS - 1);

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StPress1 = 3'd1,
        StWait2  = 3'd2,
        StPress2 = 3'd3,
        StLong   = 3'd4
    } state_e;

    state_e         state_q, state_d;
    logic [PsW-1:0] presc_q, presc_d;
    logic [MsW-1:0] ms_q, ms_d;
    logic           single_q, single_d;
    logic           double_q, double_d;
    logic           long_q, long_d;
    logic           repeat_q, repeat_d;
    logic           held_q, held_d;
    logic [2:0]     state_dbg_q, state_dbg_d;

    logic ms_tick;
    logic pe;
    logic ne;
    logic clr;

    always_comb begin
        // Simultaneous press and release edges cancel each other out.
        pe      = btn_pe & ~btn_ne;
        ne      = btn_ne & ~btn_pe;
        ms_tick = (presc_q == PsLast);

        state_d  = state_q;
        single_d = 1'b0;
        double_d = 1'b0;
        long_d   = 1'b0;
        repeat_d = 1'b0;
        clr      = 1'b0;

        // A timeout fires on the tick that takes the ms count to its limit.
        unique case (state_q)
            StIdle: begin
                if (pe) state_d = StPress1;
            end
            StPress1: begin
                if (ne) begin
                    state_d = StWait2;
                end else if (ms_tick && ms_q == LongEnd) begin
                    long_d  = 1'b1;
                    state_d = StLong;
                end
            end
            StWait2: begin
                if (pe) begin
                    double_d = 1'b1;
                    state_d  = StPress2;
                end else if (ms_tick && ms_q == DblEnd) begin
                    single_d = 1'b1;
                    state_d  = StIdle;
                end
            end
            StPress2: begin
                if (ne) state_d = StIdle;
            end
            StLong: begin
                if (ne) begin
                    state_d = StIdle;
                end else if (ms_tick && ms_q == RepEnd) begin
                    repeat_d = 1'b1;
                    clr      = 1'b1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (state_d != state_q) clr = 1'b1;

        if (clr || ms_tick) presc_d = '0;
        else                presc_d = presc_q + PsW'(1);

        // Saturate rather than wrap while idling in untimed states.
        if (clr)                      ms_d = '0;
        else if (ms_tick && ms_q != '1) ms_d = ms_q + MsW'(1);
        else                          ms_d = ms_q;

        held_d      = (state_q == StPress1) || (state_q == StPress2) || (state_q == StLong);
        state_dbg_d = state_q;
    end

    always_ff @(posedge clk or posedge reset_p) begin
        if (reset_p) begin
            state_q     <= StIdle;
            presc_q     <= '0;
            ms_q        <= '0;
            single_q    <= 1'b0;
            double_q    <= 1'b0;
            long_q      <= 1'b0;
            repeat_q    <= 1'b0;
            held_q      <= 1'b0;
            state_dbg_q <= 3'd0;
        end else begin
            state_q     <= state_d;
            presc_q     <= presc_d;
            ms_q        <= ms_d;
            single_q    <= single_d;
            double_q    <= double_d;
            long_q      <= long_d;
            repeat_q    <= repeat_d;
            held_q      <= held_d;
            state_dbg_q <= state_dbg_d;
        end
    end

    assign single_click = single_q;
    assign double_click = double_q;
    assign long_press   = long_q;
    assign repeat_pulse = repeat_q;
    assign held         = held_q;
    assign state_dbg    = state_dbg_q;

endmodule
